// File: rtl/cv32e40s_mult_arbiter.sv
// Shares one cv32e40s_mult between two requesters (port 0 = EX stage, port 1 = secondary issuer).
// Latency: zero added cycles; the granted port is forwarded combinationally in both directions.
// Backpressure: mult ready/valid pass straight through to the granted port; the other port stalls while busy.
module cv32e40s_mult_arbiter #(
    parameter int unsigned RR_ARB = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    // Requester side. Operator encoding: 0 = MUL_M32, 1 = MUL_H.
    input  logic [1:0]       req_valid_i,
    input  logic [1:0]       req_operator_i,
    input  logic [1:0][1:0]  req_signed_i,
    input  logic [1:0][31:0] req_op_a_i,
    input  logic [1:0][31:0] req_op_b_i,
    input  logic [1:0]       req_halt_i,
    input  logic [1:0]       req_kill_i,
    output logic [1:0]       req_ready_o,
    output logic [1:0]       rsp_valid_o,
    output logic [31:0]      rsp_result_o,
    input  logic [1:0]       rsp_ready_i,

    // Multiplier side
    output logic             mul_valid_o,
    output logic             mul_operator_o,
    output logic [1:0]       mul_signed_o,
    output logic [31:0]      mul_op_a_o,
    output logic [31:0]      mul_op_b_o,
    output logic             mul_halt_o,
    output logic             mul_kill_o,
    output logic             mul_ready_o,
    input  logic [31:0]      mul_result_i,
    input  logic             mul_valid_i,
    input  logic             mul_ready_i
);

    localparam bit RR_EN = (RR_ARB != 0);

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    lock_state_e state_q;
    lock_state_e state_d;
    logic        owner_q;
    logic        owner_d;
    logic        rr_pref_q;
    logic        rr_pref_d;
    logic        gnt;
    logic        done;

    // Grant selection: a held lock always wins; otherwise pick among valid ports,
    // and with no requester keep pointing at the last owner so the mult inputs stay quiet.
    always_comb begin
        gnt = owner_q;
        if (state_q == FREE) begin
            case (req_valid_i)
                2'b01:   gnt = 1'b0;
                2'b10:   gnt = 1'b1;
                2'b11:   gnt = RR_EN ? rr_pref_q : 1'b0;
                default: gnt = owner_q;
            endcase
        end
    end

    // Forward the granted port to the multiplier and route the response back to it.
    // The non-granted port never sees the mult; it is ready only if idle or being killed.
    always_comb begin
        mul_valid_o    = req_valid_i[gnt];
        mul_operator_o = req_operator_i[gnt];
        mul_signed_o   = req_signed_i[gnt];
        mul_op_a_o     = req_op_a_i[gnt];
        mul_op_b_o     = req_op_b_i[gnt];
        mul_halt_o     = req_halt_i[gnt];
        mul_kill_o     = req_kill_i[gnt];
        mul_ready_o    = rsp_ready_i[gnt];

        rsp_valid_o      = 2'b00;
        rsp_valid_o[gnt] = mul_valid_i;

        req_ready_o      = ~req_valid_i | req_kill_i;
        req_ready_o[gnt] = mul_ready_i;
    end

    assign rsp_result_o = mul_result_i;

    // A result counts as consumed only if the owner accepts it and is not killing it.
    assign done = mul_valid_i && rsp_ready_i[gnt] && !req_kill_i[gnt];

    // Lock next-state: lock whenever the granted op does not finish this cycle (MUL_H,
    // halted or back-pressured M32); release on completion or owner kill (kill first).
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_pref_d = rr_pref_q;
        case (state_q)
            FREE: begin
                if (req_valid_i[gnt] && !req_kill_i[gnt] && !done) begin
                    state_d = LOCKED;
                    owner_d = gnt;
                end else if (done && RR_EN) begin
                    rr_pref_d = ~gnt;
                end
            end
            LOCKED: begin
                if (req_kill_i[owner_q]) begin
                    state_d = FREE;
                    if (RR_EN) begin
                        rr_pref_d = ~owner_q;
                    end
                end else if (done) begin
                    state_d = FREE;
                    if (RR_EN) begin
                        rr_pref_d = ~owner_q;
                    end
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    // Arbitration state register; shares rst_n with the mult so both restart together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FREE;
            owner_q   <= 1'b0;
            rr_pref_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_pref_q <= rr_pref_d;
        end
    end

endmodule

// File: tb/tb_cv32e40s_mult_arbiter.sv
// Directed bench for cv32e40s_mult_arbiter with a small behavioural multiplier behind it.
// The main instance uses round-robin; a second fixed-priority instance shares the request inputs.
// Inputs change 1 time unit after the rising edge, outputs are sampled 2 units later.
module tb_cv32e40s_mult_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_operator;
    logic [1:0][1:0]  req_signed;
    logic [1:0][31:0] req_op_a;
    logic [1:0][31:0] req_op_b;
    logic [1:0]       req_halt;
    logic [1:0]       req_kill;
    logic [1:0]       rsp_ready;

    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic        mul_valid_o, mul_operator_o, mul_halt_o, mul_kill_o, mul_ready_o;
    logic [1:0]  mul_signed_o;
    logic [31:0] mul_op_a_o, mul_op_b_o;
    logic [31:0] mul_result_i;
    logic        mul_valid_i, mul_ready_i;

    logic [1:0]  fp_req_ready;
    logic [1:0]  fp_rsp_valid;
    logic [31:0] fp_rsp_result;
    logic        fp_mul_valid_o, fp_mul_operator_o, fp_mul_halt_o, fp_mul_kill_o, fp_mul_ready_o;
    logic [1:0]  fp_mul_signed_o;
    logic [31:0] fp_mul_op_a_o, fp_mul_op_b_o;
    logic [31:0] fp_mul_result_i;
    logic        fp_mul_valid_i, fp_mul_ready_i;

    int tests_run;
    int tests_failed;

    cv32e40s_mult_arbiter #(.RR_ARB(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_operator_i(req_operator), .req_signed_i(req_signed),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_halt_i(req_halt), .req_kill_i(req_kill),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result),
        .rsp_ready_i(rsp_ready),
        .mul_valid_o(mul_valid_o), .mul_operator_o(mul_operator_o), .mul_signed_o(mul_signed_o),
        .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o), .mul_halt_o(mul_halt_o),
        .mul_kill_o(mul_kill_o), .mul_ready_o(mul_ready_o),
        .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i), .mul_ready_i(mul_ready_i)
    );

    cv32e40s_mult_arbiter #(.RR_ARB(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_operator_i(req_operator), .req_signed_i(req_signed),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_halt_i(req_halt), .req_kill_i(req_kill),
        .req_ready_o(fp_req_ready), .rsp_valid_o(fp_rsp_valid), .rsp_result_o(fp_rsp_result),
        .rsp_ready_i(rsp_ready),
        .mul_valid_o(fp_mul_valid_o), .mul_operator_o(fp_mul_operator_o), .mul_signed_o(fp_mul_signed_o),
        .mul_op_a_o(fp_mul_op_a_o), .mul_op_b_o(fp_mul_op_b_o), .mul_halt_o(fp_mul_halt_o),
        .mul_kill_o(fp_mul_kill_o), .mul_ready_o(fp_mul_ready_o),
        .mul_result_i(fp_mul_result_i), .mul_valid_i(fp_mul_valid_i), .mul_ready_i(fp_mul_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier for the main instance: M32 completes in one cycle,
    // MUL_H takes four (step counter 0..3, result on step 3), kill restarts it.
    logic [1:0]  mcnt;
    logic [63:0] mprod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 2'd0;
        end else if (mul_kill_o) begin
            mcnt <= 2'd0;
        end else if (mul_valid_o && mul_operator_o && !mul_halt_o) begin
            if (mcnt != 2'd3) begin
                mcnt <= mcnt + 2'd1;
            end else if (mul_ready_o) begin
                mcnt <= 2'd0;
            end
        end
    end

    always_comb begin
        mprod        = {32'd0, mul_op_a_o} * {32'd0, mul_op_b_o};
        mul_result_i = mul_operator_o ? mprod[63:32] : mprod[31:0];
        mul_valid_i  = mul_valid_o && !mul_halt_o && !mul_kill_o &&
                       (!mul_operator_o || (mcnt == 2'd3));
        mul_ready_i  = mul_kill_o || !mul_valid_o ||
                       (!mul_halt_o && mul_ready_o && (!mul_operator_o || (mcnt == 2'd3)));
    end

    // Single-cycle-only model for the fixed-priority instance.
    assign fp_mul_result_i = fp_mul_op_a_o * fp_mul_op_b_o;
    assign fp_mul_valid_i  = fp_mul_valid_o;
    assign fp_mul_ready_i  = fp_mul_ready_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        req_valid    = 2'b00;
        req_operator = 2'b00;
        req_signed   = '0;
        req_op_a     = '0;
        req_op_b     = '0;
        req_halt     = 2'b00;
        req_kill     = 2'b00;
        rsp_ready    = 2'b11;
    endtask

    task automatic set_req(input int p, input logic v, input logic op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[p]    = v;
        req_operator[p] = op;
        req_op_a[p]     = a;
        req_op_b[p]     = b;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_inputs();
        rst_n = 1'b0;

        // Reset / idle outputs
        settle();
        chk("rst_req_ready", {30'd0, req_ready}, 32'h3);
        chk("rst_mul_valid", {31'd0, mul_valid_o}, 32'h0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        req_op_a[0] = 32'h11;
        req_op_a[1] = 32'h22;
        settle();
        chk("idle_op_a_port0", mul_op_a_o, 32'h11);
        chk("idle_req_ready", {30'd0, req_ready}, 32'h3);

        // Port 0 M32 5x7, port 1 idle: same-cycle result, no lock
        tick();
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd7);
        settle();
        chk("m32_result", rsp_result, 32'd35);
        chk("m32_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("m32_req_ready", {30'd0, req_ready}, 32'h3);
        tick();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'd4, 32'd4);
        settle();
        chk("nolock_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("nolock_result", rsp_result, 32'd16);

        // Both ports valid after reset: round-robin alternates, fixed priority keeps port 0
        do_reset();
        tick();
        set_req(0, 1'b1, 1'b0, 32'd3, 32'd4);
        set_req(1, 1'b1, 1'b0, 32'd5, 32'd6);
        settle();
        chk("rr0_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("rr0_result", rsp_result, 32'd12);
        chk("rr0_req_ready", {30'd0, req_ready}, 32'h1);
        chk("fp0_rsp_valid", {30'd0, fp_rsp_valid}, 32'h1);
        tick();
        settle();
        chk("rr1_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("rr1_result", rsp_result, 32'd30);
        chk("rr1_req_ready", {30'd0, req_ready}, 32'h2);
        chk("fp1_rsp_valid", {30'd0, fp_rsp_valid}, 32'h1);
        chk("fp1_result", fp_rsp_result, 32'd12);
        tick();
        settle();
        chk("rr2_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("fp2_rsp_valid", {30'd0, fp_rsp_valid}, 32'h1);

        // Port 1 MUL_H 0xFFFFFFFF x 0xFFFFFFFF (signed 11); port 0 arrives at cycle 1
        do_reset();
        tick();
        set_req(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_signed[1] = 2'b11;
        settle();
        chk("mulh_c0_signed", {30'd0, mul_signed_o}, 32'h3);
        chk("mulh_c0_operator", {31'd0, mul_operator_o}, 32'h1);
        chk("mulh_c0_req_ready", {30'd0, req_ready}, 32'h1);
        tick();
        set_req(0, 1'b1, 1'b0, 32'd2, 32'd2);
        settle();
        chk("mulh_c1_req_ready", {30'd0, req_ready}, 32'h0);
        chk("mulh_c1_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        tick();
        settle();
        chk("mulh_c2_req_ready", {30'd0, req_ready}, 32'h0);
        tick();
        settle();
        chk("mulh_c3_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("mulh_c3_result", rsp_result, 32'hFFFF_FFFE);
        chk("mulh_c3_req_ready", {30'd0, req_ready}, 32'h2);
        tick();
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        req_signed[1] = 2'b00;
        settle();
        chk("mulh_after_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("mulh_after_result", rsp_result, 32'd4);
        chk("mulh_after_req_ready", {30'd0, req_ready}, 32'h3);

        // Owner kill during MUL_H at cycle 2 frees the arbiter
        do_reset();
        tick();
        set_req(0, 1'b1, 1'b1, 32'h1_0000, 32'h1_0000);
        tick();
        set_req(1, 1'b1, 1'b0, 32'd2, 32'd3);
        settle();
        chk("okill_c1_req_ready", {30'd0, req_ready}, 32'h0);
        tick();
        req_kill[0] = 1'b1;
        settle();
        chk("okill_mul_kill", {31'd0, mul_kill_o}, 32'h1);
        chk("okill_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        tick();
        req_kill[0] = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        settle();
        chk("okill_next_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("okill_next_result", rsp_result, 32'd6);

        // Non-owner kill while locked does not disturb the owner
        do_reset();
        tick();
        set_req(0, 1'b1, 1'b1, 32'h1_0000, 32'h3_0000);
        tick();
        set_req(1, 1'b1, 1'b0, 32'd9, 32'd9);
        req_kill[1] = 1'b1;
        settle();
        chk("nkill_req_ready1", {31'd0, req_ready[1]}, 32'h1);
        chk("nkill_mul_kill", {31'd0, mul_kill_o}, 32'h0);
        tick();
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        req_kill[1] = 1'b0;
        tick();
        settle();
        chk("nkill_owner_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("nkill_owner_result", rsp_result, 32'd3);

        // Owner holds rsp_ready low for 3 cycles at MUL_H completion
        do_reset();
        tick();
        rsp_ready = 2'b10;
        set_req(0, 1'b1, 1'b1, 32'h2_0000, 32'h2_0000);
        tick();
        set_req(1, 1'b1, 1'b0, 32'd3, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk($sformatf("hold%0d_rsp_valid", i), {30'd0, rsp_valid}, 32'h1);
            chk($sformatf("hold%0d_result", i), rsp_result, 32'd4);
            chk($sformatf("hold%0d_req_ready", i), {30'd0, req_ready}, 32'h0);
        end
        tick();
        rsp_ready = 2'b11;
        settle();
        chk("accept_req_ready", {30'd0, req_ready}, 32'h1);
        chk("accept_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        tick();
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        settle();
        chk("post_accept_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("post_accept_result", rsp_result, 32'd9);

        // Reset asserted in the middle of a MUL_H
        do_reset();
        tick();
        set_req(0, 1'b1, 1'b1, 32'h5_0000, 32'h5_0000);
        tick();
        tick();
        clear_inputs();
        rst_n = 1'b0;
        settle();
        chk("midrst_req_ready", {30'd0, req_ready}, 32'h3);
        chk("midrst_mul_valid", {31'd0, mul_valid_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("midrst_rel_req_ready", {30'd0, req_ready}, 32'h3);
        tick();
        set_req(1, 1'b1, 1'b0, 32'd7, 32'd3);
        settle();
        chk("midrst_free_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("midrst_free_result", rsp_result, 32'd21);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
